// File: rtl/ipg_pkg.sv
// Shared types and constants for the IPG read-response assembler.
package ipg_pkg;

  localparam int unsigned DefDataWidth     = 64;
  localparam int unsigned DefHdrWidth      = 16;
  localparam int unsigned DefAdrWidth      = 12;
  localparam int unsigned DefPayloadLen    = 512;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [1:0] {StIdle, StCollect, StHold} ipg_state_e;

  // Header layout: length field at the chunk MSB, address immediately below it.
  function automatic int unsigned hdr_len_msb(int unsigned data_width);
    return data_width - 1;
  endfunction

  function automatic int unsigned hdr_adr_msb(int unsigned data_width, int unsigned hdr_width);
    return data_width - hdr_width - 1;
  endfunction

  localparam int unsigned DefHdrLenMsb = hdr_len_msb(DefDataWidth);
  localparam int unsigned DefHdrAdrMsb = hdr_adr_msb(DefDataWidth, DefHdrWidth);

endpackage

// File: rtl/ipg_msb_bit_insert.sv
// Copies the top n bits of a chunk into payload[remaining-1 -: n], MSB first.
module ipg_msb_bit_insert #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned PAYLOAD_LEN = 512,
  parameter int unsigned LEN_WIDTH   = $clog2(DATA_WIDTH + 1),
  parameter int unsigned CNT_WIDTH   = $clog2(PAYLOAD_LEN + 1)
) (
  input  logic [DATA_WIDTH-1:0]  chunk_i,
  input  logic [LEN_WIDTH-1:0]   n_i,
  input  logic [CNT_WIDTH-1:0]   remaining_i,
  input  logic [PAYLOAD_LEN-1:0] payload_i,
  output logic [PAYLOAD_LEN-1:0] payload_o
);

  localparam int unsigned PIdxW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int unsigned CIdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Bit i of the chunk (counted from its MSB) lands at payload[remaining-i].
  always_comb begin
    logic [PIdxW-1:0] pidx;
    logic [CIdxW-1:0] cidx;
    payload_o = payload_i;
    pidx      = '0;
    cidx      = '0;
    for (int unsigned i = 1; i <= DATA_WIDTH; i++) begin
      if (i <= 32'(n_i) && i <= 32'(remaining_i)) begin
        pidx            = PIdxW'(32'(remaining_i) - i);
        cidx            = CIdxW'(DATA_WIDTH - i);
        payload_o[pidx] = chunk_i[cidx];
      end
    end
  end

endmodule

// File: rtl/ipg_rresp_assembler.sv
// IPG read-response assembler: header parse, MSB-first payload collection, valid/ready output.
// Optional inactivity timeout in COLLECT is built when IPG_RRESP_TIMEOUT_EN is defined.
module ipg_rresp_assembler
  import ipg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned HDR_WIDTH      = DefHdrWidth,
  parameter int unsigned ADR_WIDTH      = DefAdrWidth,
  parameter int unsigned PAYLOAD_LEN    = DefPayloadLen,
  parameter int unsigned LEN_WIDTH      = $clog2(DATA_WIDTH + 1),
  parameter int unsigned CNT_WIDTH      = $clog2(PAYLOAD_LEN + 1),
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  rx_ipg_data,
  input  logic [LEN_WIDTH-1:0]   rx_len,
  input  logic                   rresp_valid,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ADR_WIDTH-1:0]   resp_addr,
  output logic [CNT_WIDTH-1:0]   resp_bits,
  output logic [PAYLOAD_LEN-1:0] resp_payload,
  output logic                   err_len,
  output logic                   err_drop,
  output logic                   busy
);

  localparam int unsigned LenMsb = hdr_len_msb(DATA_WIDTH);
  localparam int unsigned AdrMsb = hdr_adr_msb(DATA_WIDTH, HDR_WIDTH);

  ipg_state_e             state_q, state_d;
  logic [ADR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_WIDTH-1:0]   bits_q, bits_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [PAYLOAD_LEN-1:0] payload_q, payload_d;
  logic                   err_len_q, err_len_d;
  logic                   err_drop_q, err_drop_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   busy_q, busy_d;

  logic                   active;
  logic [LEN_WIDTH-1:0]   len_c;
  logic [LEN_WIDTH-1:0]   n_c;
  logic [HDR_WIDTH-1:0]   hdr_len;
  logic [ADR_WIDTH-1:0]   hdr_adr;
  logic                   hdr_bad;
  logic [PAYLOAD_LEN-1:0] ins_payload;

`ifdef IPG_RRESP_TIMEOUT_EN
  localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoWidth-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Chunk qualification, length clamp and header field decode.
  always_comb begin
    active  = rresp_valid && (rx_len != '0);
    len_c   = (32'(rx_len) > DATA_WIDTH) ? LEN_WIDTH'(DATA_WIDTH) : rx_len;
    n_c     = (32'(len_c) < 32'(rem_q)) ? len_c : LEN_WIDTH'(rem_q);
    hdr_len = rx_ipg_data[LenMsb -: HDR_WIDTH];
    hdr_adr = rx_ipg_data[AdrMsb -: ADR_WIDTH];
    hdr_bad = (32'(len_c) < (HDR_WIDTH + ADR_WIDTH)) || (hdr_len == '0) ||
              (32'(hdr_len) > PAYLOAD_LEN);
  end

  ipg_msb_bit_insert #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PAYLOAD_LEN (PAYLOAD_LEN),
    .LEN_WIDTH   (LEN_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_insert (
    .chunk_i     (rx_ipg_data),
    .n_i         (n_c),
    .remaining_i (rem_q),
    .payload_i   (payload_q),
    .payload_o   (ins_payload)
  );

  // FSM next state; outputs are registered from the next-state view.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bits_d     = bits_q;
    rem_d      = rem_q;
    payload_d  = payload_q;
    err_len_d  = 1'b0;
    err_drop_d = 1'b0;
`ifdef IPG_RRESP_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (active) begin
          if (hdr_bad) begin
            err_len_d = 1'b1;
          end else begin
            addr_d    = hdr_adr;
            bits_d    = CNT_WIDTH'(hdr_len);
            rem_d     = CNT_WIDTH'(hdr_len);
            payload_d = '0;
            state_d   = StCollect;
`ifdef IPG_RRESP_TIMEOUT_EN
            tmo_d     = '0;
`endif
          end
        end
      end
      StCollect: begin
        if (active) begin
          payload_d = ins_payload;
          rem_d     = rem_q - CNT_WIDTH'(n_c);
          if (rem_q == CNT_WIDTH'(n_c)) state_d = StHold;
`ifdef IPG_RRESP_TIMEOUT_EN
          tmo_d     = '0;
        end else if (tmo_q == TmoWidth'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          err_len_d = 1'b1;
          payload_d = '0;
          tmo_d     = '0;
        end else begin
          tmo_d     = tmo_q + TmoWidth'(1);
`endif
        end
      end
      StHold: begin
        // IPG side cannot stall, so anything arriving now is lost.
        if (active) err_drop_d = 1'b1;
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    resp_valid_d = (state_d == StHold);
    busy_d       = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      bits_q       <= '0;
      rem_q        <= '0;
      payload_q    <= '0;
      err_len_q    <= 1'b0;
      err_drop_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef IPG_RRESP_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bits_q       <= bits_d;
      rem_q        <= rem_d;
      payload_q    <= payload_d;
      err_len_q    <= err_len_d;
      err_drop_q   <= err_drop_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
`ifdef IPG_RRESP_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_addr    = addr_q;
  assign resp_bits    = bits_q;
  assign resp_payload = payload_q;
  assign err_len      = err_len_q;
  assign err_drop     = err_drop_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ipg_rresp_assembler.sv
// Directed bench for ipg_rresp_assembler with a response scoreboard.
module tb_ipg_rresp_assembler;

  localparam int unsigned DW  = 64;
  localparam int unsigned HW  = 16;
  localparam int unsigned AW  = 12;
  localparam int unsigned PL  = 512;
  localparam int unsigned LW  = 7;
  localparam int unsigned CW  = 10;
  localparam int unsigned TMO = 8;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] rx_ipg_data;
  logic [LW-1:0] rx_len;
  logic          rresp_valid;
  logic          resp_valid;
  logic          resp_ready;
  logic [AW-1:0] resp_addr;
  logic [CW-1:0] resp_bits;
  logic [PL-1:0] resp_payload;
  logic          err_len;
  logic          err_drop;
  logic          busy;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] bits;
    logic [PL-1:0] payload;
  } resp_t;

  resp_t exp_q[$];

  int            checks = 0;
  int            errors = 0;
  int            m_rem  = 0;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] m_bits;
  logic [PL-1:0] m_pay;

  ipg_rresp_assembler #(
    .DATA_WIDTH     (DW),
    .HDR_WIDTH      (HW),
    .ADR_WIDTH      (AW),
    .PAYLOAD_LEN    (PL),
    .LEN_WIDTH      (LW),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_ipg_data  (rx_ipg_data),
    .rx_len       (rx_len),
    .rresp_valid  (rresp_valid),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_addr    (resp_addr),
    .resp_bits    (resp_bits),
    .resp_payload (resp_payload),
    .err_len      (err_len),
    .err_drop     (err_drop),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of IPG input; returns just after the sampling edge.
  task automatic drive(input logic [DW-1:0] d, input logic [LW-1:0] len, input logic v);
    @(negedge clk);
    rx_ipg_data = d;
    rx_len      = len;
    rresp_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    drive('0, '0, 1'b0);
  endtask

  task automatic check_front(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=%0h expected=response", tag, resp_addr);
    end else begin
      chk({tag, "_addr"}, PL'(resp_addr), PL'(exp_q[0].addr));
      chk({tag, "_bits"}, PL'(resp_bits), PL'(exp_q[0].bits));
      chk({tag, "_payload"}, resp_payload, exp_q[0].payload);
    end
  endtask

  // Header issued while idle; model decides good/bad independently.
  task automatic hdr(input logic [HW-1:0] len, input logic [AW-1:0] addr,
                     input logic [LW-1:0] rxlen);
    int  eff;
    logic bad;
    drive({len, addr, 36'h0}, rxlen, 1'b1);
    eff = (int'(rxlen) > 64) ? 64 : int'(rxlen);
    bad = (eff < 28) || (len == 0) || (int'(len) > 512);
    chk("hdr_err_len", PL'(err_len), PL'(bad));
    chk("hdr_busy", PL'(busy), PL'(!bad));
    if (!bad) begin
      m_rem  = int'(len);
      m_addr = addr;
      m_bits = CW'(len);
      m_pay  = '0;
    end
  endtask

  task automatic chunk(input logic [DW-1:0] d, input logic [LW-1:0] rxlen);
    int            n;
    logic [PL-1:0] c;
    drive(d, rxlen, 1'b1);
    n = (int'(rxlen) > 64) ? 64 : int'(rxlen);
    if (n > m_rem) n = m_rem;
    c = ({448'h0, d} >> (64 - n)) << (m_rem - n);
    m_pay = m_pay | c;
    m_rem = m_rem - n;
    if (m_rem == 0) begin
      exp_q.push_back('{m_addr, m_bits, m_pay});
      chk("chunk_resp_valid", PL'(resp_valid), PL'(1'b1));
      check_front("resp");
    end else begin
      chk("chunk_resp_valid", PL'(resp_valid), PL'(1'b0));
      chk("chunk_busy", PL'(busy), PL'(1'b1));
    end
  endtask

  // Handshake the held response, optionally with a colliding chunk.
  task automatic take(input logic with_drop);
    @(negedge clk);
    resp_ready  = 1'b1;
    rx_ipg_data = 64'h1111_2222_3333_4444;
    rx_len      = with_drop ? LW'(32) : LW'(0);
    rresp_valid = with_drop;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    chk("take_resp_valid", PL'(resp_valid), PL'(1'b0));
    chk("take_busy", PL'(busy), PL'(1'b0));
    chk("take_err_drop", PL'(err_drop), PL'(with_drop));
    resp_ready  = 1'b0;
    rresp_valid = 1'b0;
    rx_len      = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, PL'(resp_valid), '0);
    chk({tag, "_busy"}, PL'(busy), '0);
    chk({tag, "_err_len"}, PL'(err_len), '0);
    chk({tag, "_err_drop"}, PL'(err_drop), '0);
    chk({tag, "_addr"}, PL'(resp_addr), '0);
    chk({tag, "_bits"}, PL'(resp_bits), '0);
    chk({tag, "_payload"}, resp_payload, '0);
  endtask

  initial begin
    logic [DW-1:0] d;
    reset_n     = 1'b0;
    rx_ipg_data = '0;
    rx_len      = '0;
    rresp_valid = 1'b0;
    resp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Basic three-chunk response, held while resp_ready is low.
    hdr(16'h0050, 12'hABC, 7'd28);
    chunk(64'hDEAD_BEEF_0123_4567, 7'd64);
    chunk(64'h89AB_0000_0000_0000, 7'd16);
    chk("t1_payload_const", resp_payload, PL'(80'hDEADBEEF0123456789AB));
    idle_cyc();
    chk("t1_hold_valid", PL'(resp_valid), PL'(1'b1));
    take(1'b0);

    // Ready high in advance; oversized rx_len clamps; trailing bits discarded.
    resp_ready = 1'b1;
    hdr(16'h0050, 12'hABC, 7'd28);
    chunk(64'hDEAD_BEEF_0123_4567, 7'd100);
    chunk(64'h89AB_F000_0000_0000, 7'd20);
    chk("t2_payload_const", resp_payload, PL'(80'hDEADBEEF0123456789AB));
    idle_cyc();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    chk("t2_release_valid", PL'(resp_valid), PL'(1'b0));
    chk("t2_release_busy", PL'(busy), PL'(1'b0));
    resp_ready = 1'b0;

    // Bad headers: oversize, zero length, short rx_len.
    hdr(16'h0201, 12'h111, 7'd28);
    idle_cyc();
    chk("t3_err_len_one_cycle", PL'(err_len), PL'(1'b0));
    hdr(16'h0000, 12'h222, 7'd28);
    hdr(16'h0050, 12'h333, 7'd20);
    idle_cyc();
    chk("t3_err_len_clear", PL'(err_len), PL'(1'b0));
    chk("t3_busy", PL'(busy), PL'(1'b0));

    // Maximum-length payload in eight full chunks.
    hdr(16'h0200, 12'h7FF, 7'd64);
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      chunk(d, 7'd64);
    end
    take(1'b0);

    // Drops while held, then a drop coinciding with the handshake.
    hdr(16'h0040, 12'h123, 7'd28);
    chunk(64'hCAFE_F00D_5555_AAAA, 7'd64);
    for (int i = 0; i < 3; i++) begin
      drive(64'hFFFF_FFFF_FFFF_FFFF, 7'd32, 1'b1);
      chk("t4_err_drop", PL'(err_drop), PL'(1'b1));
      chk("t4_hold_valid", PL'(resp_valid), PL'(1'b1));
      check_front("t4_held");
    end
    idle_cyc();
    chk("t4_err_drop_clear", PL'(err_drop), PL'(1'b0));
    take(1'b1);
    idle_cyc();
    chk("t4_err_drop_after", PL'(err_drop), PL'(1'b0));

    // Asynchronous reset mid-assembly, then a fresh response.
    hdr(16'h0080, 12'h456, 7'd28);
    chunk(64'h0123_4567_89AB_CDEF, 7'd64);
    @(negedge clk);
    rresp_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    m_rem = 0;
    @(negedge clk);
    reset_n = 1'b1;
    hdr(16'h0030, 12'h321, 7'd28);
    chunk(64'hA5A5_5A5A_C3C3_0000, 7'd48);
    chk("t5_payload_const", resp_payload, PL'(48'hA5A55A5AC3C3));
    take(1'b0);

`ifdef IPG_RRESP_TIMEOUT_EN
    // Idle stall aborts COLLECT; zero-length valids count as idle.
    hdr(16'h0040, 12'h0AA, 7'd28);
    repeat (5) idle_cyc();
    chunk(64'hFF00_0000_0000_0000, 7'd8);
    for (int i = 0; i < 7; i++) begin
      drive(64'hFFFF_0000_0000_0000, 7'd0, i[0]);
      chk("t6_busy_waiting", PL'(busy), PL'(1'b1));
      chk("t6_no_err_yet", PL'(err_len), PL'(1'b0));
    end
    drive(64'h0, 7'd0, 1'b1);
    chk("t6_timeout_err_len", PL'(err_len), PL'(1'b1));
    chk("t6_timeout_busy", PL'(busy), PL'(1'b0));
    idle_cyc();
    chk("t6_err_len_clear", PL'(err_len), PL'(1'b0));
    m_rem = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipg_rresp_assembler.md
# ipg_rresp_assembler

Parametrised successor to the fixed-width IPG read-response receiver. It parses a header chunk from the inter-packet-gap side channel, then assembles a variable-length payload from MSB-aligned chunks of any valid-bit count. It presents the completed response, with its address, on a valid/ready output toward the memory/response consumer. It sits between the IPG RX extractor (`rx_ipg_data`/`rx_len`/`rresp_valid`) and the response write path. It adds length checking, drop reporting and an optional inactivity timeout.

## Interface
Parameters:
- `DATA_WIDTH`, 64: IPG chunk width.
- `HDR_WIDTH`, 16: payload-length field width, in bits.
- `ADR_WIDTH`, 12: address field width.
- `PAYLOAD_LEN`, 512: maximum payload, in bits.
- `LEN_WIDTH`, $clog2(DATA_WIDTH+1): `rx_len` width.
- `CNT_WIDTH`, $clog2(PAYLOAD_LEN+1): payload bit counter width.
- `TIMEOUT_CYCLES`, 1024: inactivity limit. Used only with the timeout macro.

Ports:
- `clk`  in  1: the single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rx_ipg_data`  in  DATA_WIDTH: chunk data. Valid bits are MSB-aligned.
- `rx_len`  in  LEN_WIDTH: number of valid bits in the chunk. Values above DATA_WIDTH are clamped to DATA_WIDTH.
- `rresp_valid`  in  1: chunk qualifier.
- `resp_valid`  out  1: assembled response available.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_addr`  out  ADR_WIDTH: response address.
- `resp_bits`  out  CNT_WIDTH: payload length, in bits.
- `resp_payload`  out  PAYLOAD_LEN: payload, right-aligned in `[resp_bits-1:0]`. Upper bits are zero.
- `err_len`  out  1: one-cycle pulse for a bad header.
- `err_drop`  out  1: one-cycle pulse for a chunk dropped in HOLD.
- `busy`  out  1: state is not IDLE.

## Operation
- A chunk is active when `rresp_valid` is 1 and `rx_len` is nonzero. Any other cycle is idle.
- States: IDLE, COLLECT, HOLD. Reset value is IDLE.
- IDLE, active chunk: the chunk is a header.
  - Length is `rx_ipg_data[DATA_WIDTH-1 -: HDR_WIDTH]`.
  - Address is the next ADR_WIDTH bits down.
  - Bits below the header fields are discarded.
  - The header is bad if:
    - `rx_len` < HDR_WIDTH+ADR_WIDTH, or
    - length = 0, or
    - length > PAYLOAD_LEN.
  - Bad header: pulse `err_len` and stay in IDLE.
  - Good header: latch address and length, set remaining = length, clear the payload register, go to COLLECT.
- COLLECT, active chunk:
  - Take n = min(`rx_len`, remaining).
  - For i = 1..n: `payload[remaining-i]` = `rx_ipg_data[DATA_WIDTH-i]`. The first-received bit lands at the payload MSB.
  - Chunk bits beyond n are discarded.
  - remaining -= n. If remaining reaches 0, go to HOLD.
  - Idle cycles keep COLLECT with no change.
- HOLD:
  - `resp_valid` = 1. `resp_addr`, `resp_bits` and `resp_payload` are stable.
  - `resp_valid && resp_ready`: go to IDLE.
  - An active chunk arriving in HOLD is dropped and pulses `err_drop`. The IPG side cannot be back-pressured. The held response is unaffected.
  - In the cycle HOLD→IDLE, a simultaneous active chunk is also dropped, with `err_drop`.
- `reset_n` low at any time: state goes to IDLE immediately.
  - All outputs are 0, including `resp_payload`, counters and flags.
  - A partial assembly is discarded without an error pulse.

## Timing
- All outputs are registered.
- A header in cycle N gives `busy` = 1 in cycle N+1.
- The final payload chunk in cycle M gives `resp_valid` = 1 in cycle M+1.
- `err_len` and `err_drop` are high in the cycle after the offending chunk, for exactly 1 cycle.
- Handshake: `resp_valid` does not drop until the cycle after `resp_ready` is sampled high with it. `resp_ready` may be high before `resp_valid`.
- Minimum response: header plus one chunk gives 2 input cycles to `resp_valid`.
- Throughput: one chunk per cycle in COLLECT.

## Configuration
- `IPG_RRESP_TIMEOUT_EN` defined:
  - A CNT counter runs in COLLECT. It clears on every active chunk and increments on idle cycles.
  - At TIMEOUT_CYCLES it aborts to IDLE, pulses `err_len`, and discards the partial payload.
  - HOLD is never timed out.
- Undefined: no counter is built. COLLECT waits indefinitely.

## Structure
- Shared package `ipg_pkg` holds:
  - the state enum (IDLE/COLLECT/HOLD);
  - header field offset constants, derived from DATA_WIDTH/HDR_WIDTH/ADR_WIDTH;
  - the default widths.
- One sub-module, `ipg_msb_bit_insert`: combinational insertion of the top n bits of a chunk at position `remaining` in the payload vector. This isolates the variable-index loop from the FSM.

## Test plan
- Header 64'h0050_ABC0_0000_0000 (rx_len 28), then 64'hDEAD_BEEF_0123_4567 (rx_len 64), then 64'h89AB_0000_0000_0000 (rx_len 16). Required response: `resp_valid` the cycle after the last chunk, `resp_addr`=12'hABC, `resp_bits`=80, `resp_payload[79:0]`=80'hDEADBEEF0123456789AB, upper bits zero.
- Same stream with the last chunk at rx_len 20 (data 64'h89AB_F000_…). Required: extra 4 bits discarded, identical payload.
- Header length 16'h0201 (513 > 512), then header length 0, then header with rx_len 20. Required: three `err_len` pulses, `busy` stays 0.
- Complete a response with `resp_ready`=0 and send 3 active chunks during HOLD. Required: 3 `err_drop` pulses, payload unchanged. Raising `resp_ready` returns the block to IDLE next cycle.
- Deassert `reset_n` after 1 of 2 payload chunks. Required: immediate IDLE, all outputs 0. A fresh header after release assembles correctly.
- `IPG_RRESP_TIMEOUT_EN` with TIMEOUT_CYCLES=8: stall COLLECT for 8 idle cycles. Required: `err_len` pulse, return to IDLE. Toggling `rresp_valid` with rx_len 0 does not reset the counter.
